// File: rtl/fp_align_seq.sv
// Exponent-alignment sequencer for the FP add/sub path.
// Picks the larger-exponent operand and shifts the smaller mantissa right one bit
// per clock into a {man, G, R, S} field. A start/done handshake frames each operation.
module fp_align_seq #(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned MAN_W     = 24,
    parameter int unsigned MAX_SHIFT = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [EXP_W-1:0] a_exp,
    input  logic [MAN_W-1:0] a_man,
    input  logic [EXP_W-1:0] b_exp,
    input  logic [MAN_W-1:0] b_man,
    output logic             busy,
    output logic             done,
    output logic             swap,
    output logic [EXP_W-1:0] exp_diff,
    output logic [EXP_W-1:0] big_exp,
    output logic [MAN_W-1:0] big_man,
    output logic [MAN_W+2:0] sml_man
);

    localparam logic [EXP_W-1:0] MaxShiftW = EXP_W'(MAX_SHIFT);

    typedef enum logic [1:0] {StIdle, StDiff, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic [EXP_W-1:0] a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [MAN_W-1:0] a_man_q, a_man_d, b_man_q, b_man_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             swap_q, swap_d;
    logic [EXP_W-1:0] exp_diff_q, exp_diff_d;
    logic [EXP_W-1:0] big_exp_q, big_exp_d;
    logic [MAN_W-1:0] big_man_q, big_man_d;
    logic [MAN_W+2:0] sml_man_q, sml_man_d;

    // Extra MSB of the subtraction is the borrow, so the difference never wraps
    logic [EXP_W:0]   diff_full;
    logic             borrow;
    logic [EXP_W-1:0] abs_diff;
    logic [MAN_W-1:0] small_man;

    // Magnitude and operand selection from the latched exponents
    always_comb begin
        diff_full = {1'b0, a_exp_q} - {1'b0, b_exp_q};
        borrow    = diff_full[EXP_W];
        abs_diff  = borrow ? (~diff_full[EXP_W-1:0] + EXP_W'(1)) : diff_full[EXP_W-1:0];
        small_man = borrow ? a_man_q : b_man_q;
    end

    // Next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        a_exp_d    = a_exp_q;
        a_man_d    = a_man_q;
        b_exp_d    = b_exp_q;
        b_man_d    = b_man_q;
        cnt_d      = cnt_q;
        swap_d     = swap_q;
        exp_diff_d = exp_diff_q;
        big_exp_d  = big_exp_q;
        big_man_d  = big_man_q;
        sml_man_d  = sml_man_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_exp_d = a_exp;
                    a_man_d = a_man;
                    b_exp_d = b_exp;
                    b_man_d = b_man;
                    busy_d  = 1'b1;
                    state_d = StDiff;
                end
            end
            StDiff: begin
                swap_d     = borrow;
                exp_diff_d = abs_diff;
                big_exp_d  = borrow ? b_exp_q : a_exp_q;
                big_man_d  = borrow ? b_man_q : a_man_q;
                sml_man_d  = {small_man, 3'b000};
                cnt_d      = abs_diff;
                if (abs_diff == '0) begin
                    state_d = StDone;
                end else if (abs_diff > MaxShiftW) begin
                    // Everything falls below the round position; only sticky survives
                    sml_man_d = {{(MAN_W+2){1'b0}}, |small_man};
                    state_d   = StDone;
                end else begin
                    state_d = StShift;
                end
            end
            StShift: begin
                sml_man_d = {1'b0, sml_man_q[MAN_W+2:2], sml_man_q[1] | sml_man_q[0]};
                cnt_d     = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            busy_q     <= 1'b0;
            a_exp_q    <= '0;
            a_man_q    <= '0;
            b_exp_q    <= '0;
            b_man_q    <= '0;
            cnt_q      <= '0;
            swap_q     <= 1'b0;
            exp_diff_q <= '0;
            big_exp_q  <= '0;
            big_man_q  <= '0;
            sml_man_q  <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            a_exp_q    <= a_exp_d;
            a_man_q    <= a_man_d;
            b_exp_q    <= b_exp_d;
            b_man_q    <= b_man_d;
            cnt_q      <= cnt_d;
            swap_q     <= swap_d;
            exp_diff_q <= exp_diff_d;
            big_exp_q  <= big_exp_d;
            big_man_q  <= big_man_d;
            sml_man_q  <= sml_man_d;
        end
    end

    assign busy     = busy_q;
    assign done     = (state_q == StDone);
    assign swap     = swap_q;
    assign exp_diff = exp_diff_q;
    assign big_exp  = big_exp_q;
    assign big_man  = big_man_q;
    assign sml_man  = sml_man_q;

endmodule
